// File: rtl/lvt_live_value_table_pkg.sv
// Shared LVT definitions: entry width and the accelerator port codes stored per index.
package lvt_live_value_table_pkg;
  localparam int NPORTS  = 4;
  localparam int ENTRY_W = 2;

  typedef logic [ENTRY_W-1:0] lvt_entry_t;

  localparam lvt_entry_t ACCEL_0 = 2'd0;
  localparam lvt_entry_t ACCEL_1 = 2'd1;
  localparam lvt_entry_t ACCEL_2 = 2'd2;
  localparam lvt_entry_t ACCEL_3 = 2'd3;
endpackage

// File: rtl/lvt_live_value_table_if.sv
// Write/read/flush bundle of the live value table; master drives requests, slave is the table.
interface lvt_live_value_table_if #(parameter int IDX_W = 6);
  import lvt_live_value_table_pkg::*;

  logic             wr_en_0, wr_en_1, wr_en_2, wr_en_3;
  logic [IDX_W-1:0] wr_idx_0, wr_idx_1, wr_idx_2, wr_idx_3;
  logic             rd_en_0, rd_en_1, rd_en_2, rd_en_3;
  logic [IDX_W-1:0] rd_idx_0, rd_idx_1, rd_idx_2, rd_idx_3;
  lvt_entry_t       rd_sel_0, rd_sel_1, rd_sel_2, rd_sel_3;
  logic             rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3;
  logic             flush_req;
  logic             busy;

  modport master (
    output wr_en_0, wr_en_1, wr_en_2, wr_en_3,
    output wr_idx_0, wr_idx_1, wr_idx_2, wr_idx_3,
    output rd_en_0, rd_en_1, rd_en_2, rd_en_3,
    output rd_idx_0, rd_idx_1, rd_idx_2, rd_idx_3,
    output flush_req,
    input  rd_sel_0, rd_sel_1, rd_sel_2, rd_sel_3,
    input  rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3,
    input  busy
  );

  modport slave (
    input  wr_en_0, wr_en_1, wr_en_2, wr_en_3,
    input  wr_idx_0, wr_idx_1, wr_idx_2, wr_idx_3,
    input  rd_en_0, rd_en_1, rd_en_2, rd_en_3,
    input  rd_idx_0, rd_idx_1, rd_idx_2, rd_idx_3,
    input  flush_req,
    output rd_sel_0, rd_sel_1, rd_sel_2, rd_sel_3,
    output rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3,
    output busy
  );
endinterface

// File: rtl/lvt_write_arbiter.sv
// Resolves which write port owns a given index this cycle; higher port number wins.
module lvt_write_arbiter
  import lvt_live_value_table_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic [NPORTS-1:0]            wr_en_i,
  input  logic [NPORTS-1:0][IDX_W-1:0] wr_idx_i,
  input  logic [IDX_W-1:0]             idx_i,
  output logic                         hit_o,
  output lvt_entry_t                   code_o
);
  always_comb begin
    hit_o  = 1'b0;
    code_o = ACCEL_0;
    // Ascending scan so the last match (highest port) sticks.
    for (int p = 0; p < NPORTS; p++) begin
      if (wr_en_i[p] && (wr_idx_i[p] == idx_i)) begin
        hit_o  = 1'b1;
        code_o = lvt_entry_t'(p);
      end
    end
  end
endmodule

// File: rtl/lvt_live_value_table.sv
// Live value table: per-index record of the last writing port, 4W/4R, write-first reads, init/flush sweep.
module lvt_live_value_table
  import lvt_live_value_table_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input logic                    clk,
  input logic                    reset_n,
  lvt_live_value_table_if.slave  bus
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [IDX_W:0]                cnt_q, cnt_d;
  logic                          sweep;
  logic [NPORTS-1:0]             wr_en, rd_en, wr_ok;
  logic [NPORTS-1:0][IDX_W-1:0]  wr_idx, rd_idx;
  lvt_entry_t                    table_q [DEPTH];
  logic [DEPTH-1:0]              whit;
  lvt_entry_t [DEPTH-1:0]        wcode;
  logic [NPORTS-1:0]             bhit;
  lvt_entry_t [NPORTS-1:0]       bcode;
  lvt_entry_t [NPORTS-1:0]       sel_q, sel_d;
  logic [NPORTS-1:0]             vld_q, vld_d;

  assign wr_en  = {bus.wr_en_3, bus.wr_en_2, bus.wr_en_1, bus.wr_en_0};
  assign wr_idx = {bus.wr_idx_3, bus.wr_idx_2, bus.wr_idx_1, bus.wr_idx_0};
  assign rd_en  = {bus.rd_en_3, bus.rd_en_2, bus.rd_en_1, bus.rd_en_0};
  assign rd_idx = {bus.rd_idx_3, bus.rd_idx_2, bus.rd_idx_1, bus.rd_idx_0};

  assign sweep    = (state_q == INIT);
  assign bus.busy = sweep;
  assign wr_ok    = sweep ? '0 : wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush is only honoured from IDLE, so a request during the sweep cannot extend it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + (IDX_W+1)'(1);
        if (cnt_q == (IDX_W+1)'(DEPTH-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (bus.flush_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    lvt_write_arbiter #(.IDX_W(IDX_W)) u_warb (
      .wr_en_i (wr_ok),
      .wr_idx_i(wr_idx),
      .idx_i   (IDX_W'(e)),
      .hit_o   (whit[e]),
      .code_o  (wcode[e])
    );

    always_ff @(posedge clk) begin
      if (sweep && (cnt_q == (IDX_W+1)'(e))) table_q[e] <= ACCEL_0;
      else if (whit[e])                      table_q[e] <= wcode[e];
    end
  end

  for (genvar r = 0; r < NPORTS; r++) begin : g_rd
    lvt_write_arbiter #(.IDX_W(IDX_W)) u_barb (
      .wr_en_i (wr_ok),
      .wr_idx_i(wr_idx),
      .idx_i   (rd_idx[r]),
      .hit_o   (bhit[r]),
      .code_o  (bcode[r])
    );

    // Selector only moves on an accepted read; otherwise it holds for the word mux.
    always_comb begin
      sel_d[r] = sel_q[r];
      vld_d[r] = 1'b0;
      if (rd_en[r] && !sweep) begin
        vld_d[r] = 1'b1;
        sel_d[r] = bhit[r] ? bcode[r] : table_q[rd_idx[r]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= {NPORTS{ACCEL_0}};
      vld_q <= '0;
    end else begin
      sel_q <= sel_d;
      vld_q <= vld_d;
    end
  end

  assign bus.rd_sel_0   = sel_q[0];
  assign bus.rd_sel_1   = sel_q[1];
  assign bus.rd_sel_2   = sel_q[2];
  assign bus.rd_sel_3   = sel_q[3];
  assign bus.rd_valid_0 = vld_q[0];
  assign bus.rd_valid_1 = vld_q[1];
  assign bus.rd_valid_2 = vld_q[2];
  assign bus.rd_valid_3 = vld_q[3];
endmodule

// File: tb/tb_lvt_live_value_table.sv
// Scoreboard bench for the live value table: directed writes/reads, flush and reset sweeps.
module tb_lvt_live_value_table;
  import lvt_live_value_table_pkg::*;

  localparam int IDX_W = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lvt_live_value_table_if #(.IDX_W(IDX_W)) bus();

  lvt_live_value_table #(.IDX_W(IDX_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [3:0]       wr_en, rd_en;
  logic [IDX_W-1:0] wr_idx [4];
  logic [IDX_W-1:0] rd_idx [4];
  logic             flush_req;

  assign bus.wr_en_0  = wr_en[0];  assign bus.wr_en_1  = wr_en[1];
  assign bus.wr_en_2  = wr_en[2];  assign bus.wr_en_3  = wr_en[3];
  assign bus.wr_idx_0 = wr_idx[0]; assign bus.wr_idx_1 = wr_idx[1];
  assign bus.wr_idx_2 = wr_idx[2]; assign bus.wr_idx_3 = wr_idx[3];
  assign bus.rd_en_0  = rd_en[0];  assign bus.rd_en_1  = rd_en[1];
  assign bus.rd_en_2  = rd_en[2];  assign bus.rd_en_3  = rd_en[3];
  assign bus.rd_idx_0 = rd_idx[0]; assign bus.rd_idx_1 = rd_idx[1];
  assign bus.rd_idx_2 = rd_idx[2]; assign bus.rd_idx_3 = rd_idx[3];
  assign bus.flush_req = flush_req;

  logic [3:0] act_v;
  lvt_entry_t act_s [4];
  assign act_v = {bus.rd_valid_3, bus.rd_valid_2, bus.rd_valid_1, bus.rd_valid_0};
  assign act_s[0] = bus.rd_sel_0;
  assign act_s[1] = bus.rd_sel_1;
  assign act_s[2] = bus.rd_sel_2;
  assign act_s[3] = bus.rd_sel_3;

  typedef struct {
    int cyc;
    int port;
    bit v;
    int sel;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every negedge, match DUT read outputs against responses due this cycle.
  bit ev [4];
  int es [4];
  bit seen [4];
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      ev[p] = 1'b0; es[p] = 0; seen[p] = 1'b0;
    end
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        if (sbq[i].cyc < cyc) chk($sformatf("late_rsp_p%0d", sbq[i].port), cyc, sbq[i].cyc);
        else begin
          ev[sbq[i].port]   = sbq[i].v;
          es[sbq[i].port]   = sbq[i].sel;
          seen[sbq[i].port] = 1'b1;
        end
        sbq.delete(i);
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (seen[p]) begin
        chk($sformatf("rd_valid_%0d", p), int'(act_v[p]), int'(ev[p]));
        if (ev[p]) chk($sformatf("rd_sel_%0d", p), int'(act_s[p]), es[p]);
      end else if (act_v[p]) begin
        chk($sformatf("spurious_valid_%0d", p), 1, 0);
      end
    end
  end

  task automatic rd(input int p, input int idx, input bit v, input int s);
    exp_t e;
    rd_en[p]  = 1'b1;
    rd_idx[p] = IDX_W'(idx);
    e.cyc = cyc + 1; e.port = p; e.v = v; e.sel = s;
    sbq.push_back(e);
  endtask

  task automatic wr(input int p, input int idx);
    wr_en[p]  = 1'b1;
    wr_idx[p] = IDX_W'(idx);
  endtask

  task automatic step();
    @(negedge clk);
    wr_en = '0; rd_en = '0; flush_req = 1'b0;
  endtask

  // Counts negedges with busy high; optional traffic and a second flush mid-sweep.
  task automatic count_busy(input int flush_at, input int stop_at, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      wr_en = '0; rd_en = '0; flush_req = 1'b0;
      if (!bus.busy) break;
      n++;
      if (n == stop_at) break;
      if (flush_at > 0) begin
        if (n == 5) rd(1, 10, 1'b0, 0);
        if (n == 10) wr(2, 10);
        if (n == flush_at) flush_req = 1'b1;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 1);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s_valid_%0d", tag, p), int'(act_v[p]), 0);
      chk($sformatf("%s_sel_%0d", tag, p), int'(act_s[p]), int'(ACCEL_0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; wr_en = '0; rd_en = '0; flush_req = 1'b0;
    for (int p = 0; p < 4; p++) begin
      wr_idx[p] = '0; rd_idx[p] = '0;
    end

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1 reset_n = 1'b1;
    count_busy(0, 0, n);
    chk("init_busy_cycles", n, DEPTH);

    rd(0, 5, 1'b1, ACCEL_0); rd(1, 0, 1'b1, ACCEL_0);
    rd(2, 63, 1'b1, ACCEL_0); rd(3, 32, 1'b1, ACCEL_0);
    step();
    wr(2, 10); step();
    rd(0, 10, 1'b1, ACCEL_2); step();
    wr(0, 7); wr(1, 7); wr(3, 7); step();
    rd(1, 7, 1'b1, ACCEL_3); step();
    wr(1, 3); rd(2, 3, 1'b1, ACCEL_1); step();
    wr(1, 20); wr(2, 20); rd(1, 20, 1'b1, ACCEL_2); wr(3, 63); step();
    rd(3, 63, 1'b1, ACCEL_3); rd(0, 3, 1'b1, ACCEL_1); step();
    step(); step();
    chk("sel2_hold", int'(bus.rd_sel_2), int'(ACCEL_1));
    chk("valid2_low", int'(bus.rd_valid_2), 0);

    flush_req = 1'b1;
    count_busy(30, 0, n);
    chk("flush_busy_cycles", n, DEPTH);
    rd(0, 10, 1'b1, ACCEL_0); rd(1, 7, 1'b1, ACCEL_0); rd(3, 63, 1'b1, ACCEL_0);
    step();
    wr(3, 7); step();
    rd(0, 7, 1'b1, ACCEL_3); step();
    step();

    flush_req = 1'b1;
    count_busy(0, 20, n);
    chk("sweep_reached_20", n, 20);
    @(posedge clk); #1 reset_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #1 reset_n = 1'b1;
    count_busy(0, 0, n);
    chk("resweep_busy_cycles", n, DEPTH);
    rd(0, 7, 1'b1, ACCEL_0); rd(2, 10, 1'b1, ACCEL_0); step();
    step(); step();

    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lvt_live_value_table.md
LVT_LIVE_VALUE_TABLE -- requirements
Module: lvt_live_value_table

Interface
REQ-001 Parameter: IDX_W, default 6, index width; table depth DEPTH = 2^IDX_W entries.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 wr_en_0..wr_en_3  input  1 each  write request from accelerator port 0..3.
REQ-005 wr_idx_0..wr_idx_3  input  IDX_W each  index written by port 0..3.
REQ-006 rd_en_0..rd_en_3  input  1 each  read request on read port 0..3.
REQ-007 rd_idx_0..rd_idx_3  input  IDX_W each  index read by read port 0..3.
REQ-008 rd_sel_0..rd_sel_3  output  `LVT_ENTRY each  registered live-value selector; drives the word-mux selector.
REQ-009 rd_valid_0..rd_valid_3  output  1 each  rd_sel_N is valid this cycle.
REQ-010 flush_req  input  1  single-cycle request to re-initialise the whole table.
REQ-011 busy  output  1  high while an init/flush sweep runs.

Function
- REQ-012 Storage: DEPTH x `LVT_ENTRY un-reset flop array; each entry records which port last wrote that index.
- REQ-013 Write: wr_en_N in state IDLE stores code `ACCEL_N at wr_idx_N on the next edge.
- REQ-014 Same-cycle writes to one index: highest-numbered port wins (port 3 > 2 > 1 > 0).
- REQ-015 Read latency: exactly 1 cycle; rd_sel_N and rd_valid_N are registered from rd_en_N/rd_idx_N.
- REQ-016 Read-during-write, same index, same cycle: write-first; rd_sel_N returns the new winning code via bypass.
- REQ-017 rd_en_N low: rd_valid_N goes low next cycle; rd_sel_N holds its previous value.
- REQ-018 FSM has two states, INIT and IDLE.
- REQ-019 INIT: sweep counter clears one entry per cycle to `ACCEL_0, from 0 to DEPTH-1; after clearing DEPTH-1 -> IDLE.
- REQ-020 IDLE with flush_req=1: -> INIT, counter reset to 0.
- REQ-021 flush_req while in INIT is ignored; it neither restarts nor extends the sweep.
- REQ-022 busy = 1 exactly while in INIT; a sweep lasts DEPTH cycles.
- REQ-023 While busy: all writes are dropped, and rd_valid_N = 0 on the cycle after any read issued in INIT.
- REQ-024 Sweep counter is IDX_W+1 bits wide; terminal detect is at DEPTH-1, with no wrap into a second pass.

Reset
- REQ-025 Asserting reset_n low immediately forces state=INIT, counter=0, busy=1, all rd_valid_N=0, all rd_sel_N=`ACCEL_0.
- REQ-026 After reset_n deasserts, the table performs a full DEPTH-cycle sweep before it accepts writes.
- REQ-027 Reset asserted mid-sweep or mid-operation aborts all activity; table contents are undefined until the new sweep completes.

Structure
- REQ-028 `LVT_ENTRY and the `ACCEL_0..`ACCEL_3 codes come from the shared cache_parameters include; no local redefinition.
- REQ-029 FSM state encodings are local parameters of this module.
- REQ-030 One sub-module, lvt_write_arbiter: combinational per-index port-priority resolution, also used for the read bypass.

Verification
- REQ-031 Reset, then idle: busy=1 for 64 cycles (IDX_W=6), then 0; reading idx 5 returns `ACCEL_0 with rd_valid=1 one cycle later.
- REQ-032 Port 2 writes idx 10; next cycle read idx 10 on read port 0 -> rd_sel_0=`ACCEL_2 one cycle later.
- REQ-033 Ports 0, 1 and 3 write idx 7 in the same cycle -> subsequent read of idx 7 returns `ACCEL_3.
- REQ-034 Port 1 writes idx 3 while read port 2 reads idx 3 in the same cycle -> rd_sel_2=`ACCEL_1 next cycle.
- REQ-035 Flush during traffic:
  - flush_req in IDLE -> busy=1 for exactly 64 cycles;
  - writes issued in that window are lost; idx 10 then reads `ACCEL_0;
  - a second flush_req mid-sweep does not extend busy.
- REQ-036 reset_n pulsed low at sweep cycle 20 -> outputs reset immediately; a full 64-cycle sweep restarts after deassertion.
